// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants for the register file and its writeback path.
package cpu_defs;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; search starts at the registered pointer,
// which moves to one past the winner after each grant.
module rr_arbiter #(
   parameter int NREQ    = 3,
   parameter int RST_PTR = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt
);
   localparam int PTR_W = $clog2(NREQ);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] idx;
   logic             found;

   // Grant is forced low while reset is asserted so no requester sees ready.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
               gnt[idx] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) ptr_d = PTR_W'((k + 1) % NREQ);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= PTR_W'(RST_PTR);
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port and
// tracks registers with outstanding multi-cycle results for the hazard logic.
module regfile_wb_arbiter
   import cpu_defs::*;
#(
   parameter int NREQ    = 3,
   parameter int RST_PTR = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [REG_ADDR_W*NREQ-1:0] req_addr,
   input  logic [DATA_W*NREQ-1:0]     req_data,
   output logic                       we_o,
   output logic [REG_ADDR_W-1:0]      rw_o,
   output logic [DATA_W-1:0]          rw_data_o,
   input  logic                       rsv_valid,
   input  logic [REG_ADDR_W-1:0]      rsv_addr,
   input  logic [REG_ADDR_W-1:0]      q1_addr,
   input  logic [REG_ADDR_W-1:0]      q2_addr,
   output logic                       q1_busy,
   output logic                       q2_busy
);
   logic [NREQ-1:0]       gnt;
   logic                  we_q, we_d;
   logic [REG_ADDR_W-1:0] rw_q, rw_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [NUM_REGS-1:0]   pend_q, pend_d;

   rr_arbiter #(.NREQ(NREQ), .RST_PTR(RST_PTR)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .gnt   (gnt)
   );

   assign req_ready = gnt;

   // r0 writes are accepted but never reach the register file.
   always_comb begin
      we_d   = 1'b0;
      rw_d   = rw_q;
      data_d = data_q;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            rw_d   = req_addr[REG_ADDR_W*k +: REG_ADDR_W];
            data_d = req_data[DATA_W*k +: DATA_W];
            we_d   = (req_addr[REG_ADDR_W*k +: REG_ADDR_W] != REG_ZERO);
         end
      end
   end

   // Set is applied after clear so a fresh reservation outlives a retiring write.
   always_comb begin
      pend_d = pend_q;
      if (we_q && rw_q != REG_ZERO)          pend_d[rw_q]     = 1'b0;
      if (rsv_valid && rsv_addr != REG_ZERO) pend_d[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         rw_q   <= '0;
         data_q <= '0;
         pend_q <= '0;
      end else begin
         we_q   <= we_d;
         rw_q   <= rw_d;
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

   assign we_o      = we_q;
   assign rw_o      = rw_q;
   assign rw_data_o = data_q;
   assign q1_busy   = (q1_addr != REG_ZERO) && pend_q[q1_addr];
   assign q2_busy   = (q2_addr != REG_ZERO) && pend_q[q2_addr];
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback sources: ALU pipeline, load unit, multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake, and registers the winning write for the register file.
- Keeps a 32-entry pending scoreboard so decode can stall on registers with an outstanding multi-cycle result.
- Sits between the writeback sources and the register file's write port; its busy outputs feed the hazard/stall logic.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- RST_PTR, 0, requester index holding highest priority after reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NREQ  requester k has a write pending.
- req_ready  output  NREQ  requester k accepted this cycle (one-hot or zero).
- req_addr  input  5*NREQ  destination register; slice [5k+4:5k] for requester k.
- req_data  input  32*NREQ  write data; slice [32k+31:32k] for requester k.
- we_o  output  1  write enable to the register file.
- rw_o  output  5  write address to the register file.
- rw_data_o  output  32  write data to the register file.
- rsv_valid  input  1  decode reserves a destination for a multi-cycle result.
- rsv_addr  input  5  register being reserved.
- q1_addr  input  5  hazard query address, read port 1.
- q2_addr  input  5  hazard query address, read port 2.
- q1_busy  output  1  q1_addr has a pending write.
- q2_busy  output  1  q2_addr has a pending write.

Behaviour:
- Reset, while rst_n is low:
  - we_o=0, rw_o=0, rw_data_o=0.
  - All pending bits = 0.
  - Round-robin pointer = RST_PTR.
  - req_ready is combinational and is 0 during reset.
- Handshake:
  - A transfer happens when req_valid[k] & req_ready[k] at a posedge.
  - A requester holds valid, addr and data stable until accepted; it may not withdraw valid.
  - req_ready does not depend combinationally on the requester's own addr or data.
- Arbitration:
  - Search from the pointer upward, wrapping modulo NREQ; the first valid requester is granted.
  - At most one grant per cycle; no grant when no requester is valid.
  - After a grant to k, the pointer moves to (k+1) mod NREQ; with no grant it holds.
- Output stage:
  - On acceptance at posedge n: we_o=1, rw_o=addr, rw_data_o=data during cycle n+1.
  - The register file captures the write at the negedge inside cycle n+1.
  - we_o drops after one cycle unless another acceptance occurs.
  - Back-to-back acceptances give one write per cycle at full throughput.
- r0 writes:
  - Accepted normally (ready asserted) but produce we_o=0.
  - Never set or clear any pending bit.
- Scoreboard:
  - rsv_valid with rsv_addr!=0 sets pending[rsv_addr] at the posedge.
  - While we_o=1 and rw_o!=0, pending[rw_o] clears at the posedge ending that cycle.
  - If a set and a clear hit the same register in the same cycle, set wins (a newer reservation supersedes).
  - Reserving an already-pending register is legal; the bit stays 1.
- Busy outputs:
  - q1_busy = pending[q1_addr], q2_busy = pending[q2_addr]; purely combinational.
  - r0 always reads busy=0.
- Reset mid-operation: an unaccepted request is dropped, and a registered write not yet seen at the negedge is lost. Sources must reissue.

Decomposition:
- Shared package (cpu_defs): REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0.
- One sub-module, rr_arbiter: NREQ-wide round-robin grant with a pointer input, plus a registered pointer update.
- The scoreboard and output register stay in this module.

Test Plan:
- Reset then idle, all valid=0 -> we_o=0, req_ready=0, q1_busy=q2_busy=0.
- Single write: requester 1 at r5 = 0xDEADBEEF -> ready[1] for 1 cycle; next cycle we_o=1, rw_o=5, rw_data_o=0xDEADBEEF.
- All 3 valid continuously from reset with RST_PTR=0 -> grants 0,1,2,0,1,2; no starvation; one we_o per cycle.
- rsv r7, then q1_addr=7 -> q1_busy=1; load unit writes r7 -> q1_busy drops at the posedge ending the we_o cycle.
- Simultaneous rsv r9 and we_o to r9 -> pending[9] remains 1; a write to r0 -> ready=1, we_o=0, no pending change.
- Assert rst_n=0 mid-cycle while we_o=1 and pending bits are set -> all outputs 0 immediately, with no wait for a clock edge.
